mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- MEM-stage load/store unit sitting directly upstream of the data memory (DM).
- Converts byte-addressed, sized CPU requests into DM word accesses.
  - DM is word-addressed: 1024 words, write-enable only, 1-cycle synchronous read.
- Sub-word stores are done as read-modify-write (RMW).
- Sub-word loads are lane-extracted and sign/zero-extended.
- Asserts busy to stall the pipeline while a multi-cycle access is in flight.

Parameters:
- WORD_AW, 10, DM word-index width; DM word index = req_addr[WORD_AW+1:2].

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present this cycle.
- req_store  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the sub-word value is in the low bits.
- busy  out  1  stall; a request is accepted only when busy = 0.
- rsp_valid  out  1  one-cycle pulse; load data is valid.
- rsp_rdata  out  32  extended load result.
- misaligned  out  1  one-cycle pulse; previous accepted request was misaligned and dropped.
- dm_addr  out  32  to DM addr; bits [WORD_AW-1:0] = word index, upper bits 0.
- dm_data_in  out  32  to DM Data_In.
- dm_write_en  out  1  to DM Write_en.
- dm_data_out  in  32  from DM Data_Out; reflects the address driven in the previous cycle.

Behaviour:
- Reset values: state IDLE, busy 0, rsp_valid 0, rsp_rdata 0, misaligned 0, dm_write_en 0.
  - dm_write_en is forced to 0 in any cycle where rst = 1.
- States: IDLE, LOAD_WAIT, RMW.
- Acceptance: req_valid & ~busy in IDLE (cycle N).
  - busy = 1 exactly in LOAD_WAIT and RMW.
  - req_valid while busy is ignored; upstream must hold the request.
- Request capture: registered at the accept edge (offset, size, unsigned, wdata).
- DM address:
  - IDLE: driven combinationally from req_addr.
  - LOAD_WAIT/RMW: driven from the captured address.
- Alignment check: half with addr[0] = 1, or word with addr[1:0] != 0, is misaligned.
  - No DM write, no state change.
  - misaligned = 1 in cycle N+1 only.
  - busy stays 0.
- Word store: dm_write_en = 1 and dm_data_in = req_wdata in cycle N; the DM writes at the end of N; stays in IDLE.
- Load: IDLE -> LOAD_WAIT.
  - In cycle N+1, dm_data_out is lane-selected by the offset and extended.
  - The result is registered at the end of N+1: rsp_valid = 1 and rsp_rdata valid in cycle N+2. Load-to-use latency is 2.
  - LOAD_WAIT -> IDLE unconditionally.
- Sub-word store: IDLE -> RMW; DM read in cycle N.
  - In cycle N+1: dm_write_en = 1, dm_data_in = dm_data_out with the target byte/half lanes replaced by wdata[7:0] or wdata[15:0].
  - RMW -> IDLE. No rsp_valid.
- Little-endian lanes:
  - byte k occupies bits [8k+7:8k];
  - half at offset 0 occupies [15:0], at offset 2 occupies [31:16].
- Address wrap: bits above WORD_AW+1 are ignored (modulo 4 KiB); no error.
- Back-to-back ordering: a request accepted at N+2 after an RMW or load sees the RMW-written data, because the DM read follows the write edge.
- Reset mid-operation: rst in LOAD_WAIT or RMW aborts the access.
  - The RMW write is suppressed.
  - No rsp_valid.
  - IDLE in the next cycle.
- Simultaneous misaligned + busy: impossible, since only accepted requests are checked.

Decomposition:
- Package mem_pkg: size encodings SZ_BYTE/SZ_HALF/SZ_WORD, state enum, WORD_AW default.
- Sub-module mem_lane_align (combinational):
  - load extract: word, offset, size, unsigned -> result;
  - store merge: old word, wdata, offset, size -> merged word.
- Top level holds the FSM and the output registers.

Test Plan:
- Word store 0xDEADBEEF to addr 0x10, then load word from 0x10 -> DM word 4 written; rsp_rdata 0xDEADBEEF two cycles after acceptance; busy high exactly one cycle.
- Word 4 = 0x11223344; sb 0xAA to 0x11 -> busy one cycle; word 4 becomes 0x1122AA44; no rsp_valid.
- Word 4 = 0x8000_7F80:
  - lb 0x10 -> 0xFFFFFF80;
  - lbu 0x10 -> 0x00000080;
  - lh 0x12 -> 0xFFFF8000;
  - lhu 0x12 -> 0x00008000.
- Misaligned: lh 0x13 and sw 0x12 -> misaligned pulse one cycle each; DM unchanged; busy 0; no rsp_valid.
- Hold: req_valid kept high across busy -> the request executes exactly once.
- Address wrap: sw 0x1004 -> word index 1.
- Reset asserted in the RMW cycle of sh 0xBEEF to 0x22 -> dm_write_en 0, word 8 unchanged, outputs at reset values, next request accepted normally.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and helpers for the MEM-stage load/store unit
package mem_pkg;

    localparam int WORD_AW_DEF = 10;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_WAIT = 2'd1,
        ST_RMW       = 2'd2
    } mau_state_t;

    // Size 2'b11 behaves as a word, so bit 1 alone identifies word accesses.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        if (size == SZ_HALF)
            return offset[0];
        else if (size[1])
            return offset != 2'b00;
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian lane extract for loads and lane merge for sub-word stores
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] ld_word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] ld_result,
    input  logic [31:0] st_old,
    input  logic [31:0] st_wdata,
    output logic [31:0] st_merged
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = 8'h00;
        case (offset)
            2'd0: ld_byte = ld_word[7:0];
            2'd1: ld_byte = ld_word[15:8];
            2'd2: ld_byte = ld_word[23:16];
            2'd3: ld_byte = ld_word[31:24];
            default: ld_byte = 8'h00;
        endcase
        ld_half = offset[1] ? ld_word[31:16] : ld_word[15:0];

        if (size == SZ_BYTE)
            ld_result = {{24{~is_unsigned & ld_byte[7]}}, ld_byte};
        else if (size == SZ_HALF)
            ld_result = {{16{~is_unsigned & ld_half[15]}}, ld_half};
        else
            ld_result = ld_word;
    end

    always_comb begin
        st_merged = st_old;
        if (size == SZ_BYTE) begin
            case (offset)
                2'd0: st_merged[7:0]   = st_wdata[7:0];
                2'd1: st_merged[15:8]  = st_wdata[7:0];
                2'd2: st_merged[23:16] = st_wdata[7:0];
                2'd3: st_merged[31:24] = st_wdata[7:0];
                default: st_merged = st_old;
            endcase
        end else if (size == SZ_HALF) begin
            if (offset[1])
                st_merged[31:16] = st_wdata[15:0];
            else
                st_merged[15:0]  = st_wdata[15:0];
        end else begin
            st_merged = st_wdata;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - sized CPU requests to word-addressed DM accesses with RMW sub-word stores
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int WORD_AW = WORD_AW_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        misaligned,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_data_in,
    output logic        dm_write_en,
    input  logic [31:0] dm_data_out
);

    mau_state_t         state;
    logic [WORD_AW-1:0] cap_idx;
    logic [1:0]         cap_off;
    logic [1:0]         cap_size;
    logic               cap_unsigned;
    logic [31:0]        cap_wdata;

    logic               accept;
    logic               req_mis;
    logic [WORD_AW-1:0] req_idx;
    logic [31:0]        ld_result;
    logic [31:0]        st_merged;
    logic               unused_addr_bits;

    assign req_idx          = req_addr[WORD_AW+1:2];
    assign unused_addr_bits = ^req_addr[31:WORD_AW+2];
    assign accept           = req_valid & (state == ST_IDLE);
    assign req_mis          = is_misaligned(req_size, req_addr[1:0]);
    assign busy             = (state != ST_IDLE);

    // IDLE drives the live request address so the DM read starts in the accept cycle.
    assign dm_addr    = {{(32-WORD_AW){1'b0}}, (state == ST_IDLE) ? req_idx : cap_idx};
    assign dm_data_in = (state == ST_RMW) ? st_merged : req_wdata;
    assign dm_write_en = ~rst & ((accept & req_store & req_size[1] & ~req_mis)
                                 | (state == ST_RMW));

    mem_lane_align u_lane_align (
        .ld_word     (dm_data_out),
        .offset      (cap_off),
        .size        (cap_size),
        .is_unsigned (cap_unsigned),
        .ld_result   (ld_result),
        .st_old      (dm_data_out),
        .st_wdata    (cap_wdata),
        .st_merged   (st_merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'h0;
            misaligned   <= 1'b0;
            cap_idx      <= '0;
            cap_off      <= 2'b00;
            cap_size     <= SZ_BYTE;
            cap_unsigned <= 1'b0;
            cap_wdata    <= 32'h0;
        end else begin
            rsp_valid  <= 1'b0;
            misaligned <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cap_idx      <= req_idx;
                        cap_off      <= req_addr[1:0];
                        cap_size     <= req_size;
                        cap_unsigned <= req_unsigned;
                        cap_wdata    <= req_wdata;
                        if (req_mis)
                            misaligned <= 1'b1;
                        else if (!req_store)
                            state <= ST_LOAD_WAIT;
                        else if (!req_size[1])
                            state <= ST_RMW;
                    end
                end
                ST_LOAD_WAIT: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= ld_result;
                    state     <= ST_IDLE;
                end
                ST_RMW: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
